// File: rtl/mygo_chan_arbiter_pkg.sv
// rtl/mygo_chan_arbiter_pkg.sv - shared types and helpers for the channel arbiter
`ifndef MYGO_CHAN_PKG_SV
`define MYGO_CHAN_PKG_SV

`define MYGO_HS_T(W) struct packed { logic [(W)-1:0] data; logic valid; }

package mygo_chan_pkg;

  localparam int XFER_CNT_W = 32;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/mygo_chan_arbiter_if.sv
// rtl/mygo_chan_arbiter_if.sv - sender-side and FIFO-side handshake bundle of the arbiter
interface mygo_chan_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 32,
  parameter int SRC_W = 1
);
  import mygo_chan_pkg::*;

  logic [N_REQ*WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]       req_wvalid;
  logic [N_REQ-1:0]       req_wready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [SRC_W-1:0]       out_src;
  logic [XFER_CNT_W-1:0]  xfer_count;

  modport master (
    input  req_wdata, req_wvalid, out_ready,
    output req_wready, out_data, out_valid, out_src, xfer_count
  );

  modport slave (
    output req_wdata, req_wvalid, out_ready,
    input  req_wready, out_data, out_valid, out_src, xfer_count
  );

endinterface

// File: rtl/mygo_rr_pick.sv
// rtl/mygo_rr_pick.sv - combinational rotate-priority picker, first request at or after ptr wins
module mygo_rr_pick
  import mygo_chan_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int SRC_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [SRC_W-1:0] gnt_idx,
  output logic             any
);

  localparam logic [SRC_W:0] N_W = (SRC_W+1)'(N_REQ);

  logic [SRC_W:0]   pos;
  logic [SRC_W-1:0] idx;

  // One extra bit on pos so ptr+k never overflows before the explicit wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    pos     = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, ptr} + (SRC_W+1)'(k);
      if (pos >= N_W) pos = pos - N_W;
      idx = pos[SRC_W-1:0];
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mygo_chan_arbiter.sv
// rtl/mygo_chan_arbiter.sv - round-robin multi-sender arbiter with one registered stage into a channel FIFO
module mygo_chan_arbiter
  import mygo_chan_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = 32,
  parameter int SRC_W = clog2_min1(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  mygo_chan_arbiter_if.master bus
);

  typedef `MYGO_HS_T(WIDTH) stage_t;

  stage_t                stage_q, stage_d;
  logic [SRC_W-1:0]      src_q, src_d;
  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [XFER_CNT_W-1:0] xfer_count_q, xfer_count_d;

  logic [N_REQ-1:0] gnt;
  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] gnt_data;

  mygo_rr_pick #(
    .N_REQ (N_REQ),
    .SRC_W (SRC_W)
  ) u_pick (
    .req     (bus.req_wvalid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // The stage can take a new word whenever it is empty or draining this cycle.
  assign load           = !stage_q.valid || bus.out_ready;
  assign accept         = load && gnt_any && !rst;
  assign bus.req_wready = (load && !rst) ? gnt : '0;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) gnt_data = bus.req_wdata[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    stage_d      = stage_q;
    src_d        = src_q;
    rr_ptr_d     = rr_ptr_q;
    xfer_count_d = xfer_count_q;
    if (accept) begin
      stage_d.data  = gnt_data;
      stage_d.valid = 1'b1;
      src_d         = gnt_idx;
      rr_ptr_d      = (gnt_idx == SRC_W'(N_REQ-1)) ? '0 : gnt_idx + SRC_W'(1);
      xfer_count_d  = xfer_count_q + XFER_CNT_W'(1);
    end else if (stage_q.valid && bus.out_ready) begin
      // Stale data and source are left in place; only valid drops.
      stage_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q      <= '0;
      src_q        <= '0;
      rr_ptr_q     <= '0;
      xfer_count_q <= '0;
    end else begin
      stage_q      <= stage_d;
      src_q        <= src_d;
      rr_ptr_q     <= rr_ptr_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign bus.out_data   = stage_q.data;
  assign bus.out_valid  = stage_q.valid;
  assign bus.out_src    = src_q;
  assign bus.xfer_count = xfer_count_q;

endmodule

// File: tb/tb_mygo_chan_arbiter.sv
// tb/tb_mygo_chan_arbiter.sv - self-checking bench for mygo_chan_arbiter (N_REQ=2 and N_REQ=3 instances)
module tb_mygo_chan_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mygo_chan_arbiter_if #(.N_REQ(2), .WIDTH(32), .SRC_W(1)) if2 ();
  mygo_chan_arbiter_if #(.N_REQ(3), .WIDTH(32), .SRC_W(2)) if3 ();

  mygo_chan_arbiter #(.N_REQ(2), .WIDTH(32)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  mygo_chan_arbiter #(.N_REQ(3), .WIDTH(32)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  // Reference model: index 0 tracks the 2-sender instance, index 1 the 3-sender one.
  int          nreq [2] = '{2, 3};
  int          m_ptr [2];
  bit          m_valid [2];
  logic [31:0] m_data [2];
  int          m_src [2];
  logic [31:0] m_cnt [2];

  function automatic logic [7:0] get_valid(input int d);
    return (d == 0) ? 8'(if2.req_wvalid) : 8'(if3.req_wvalid);
  endfunction

  function automatic bit get_ready(input int d);
    return (d == 0) ? if2.out_ready : if3.out_ready;
  endfunction

  function automatic logic [31:0] get_slice(input int d, input int i);
    return (d == 0) ? if2.req_wdata[i*32 +: 32] : if3.req_wdata[i*32 +: 32];
  endfunction

  // First valid sender at or after the pointer, wrapping modulo the sender count.
  function automatic int pick(input int d);
    logic [7:0] v;
    v = get_valid(d);
    for (int k = 0; k < nreq[d]; k++) begin
      if (v[(m_ptr[d] + k) % nreq[d]]) return (m_ptr[d] + k) % nreq[d];
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_wready(input int d);
    int g;
    if (rst) return 8'h00;
    if (m_valid[d] && !get_ready(d)) return 8'h00;
    g = pick(d);
    if (g < 0) return 8'h00;
    return 8'h01 << g;
  endfunction

  task automatic tick();
    bit          nv [2];
    logic [31:0] nd [2];
    int          ns [2];
    int          np [2];
    logic [31:0] nc [2];
    int          g;
    for (int d = 0; d < 2; d++) begin
      nv[d] = m_valid[d]; nd[d] = m_data[d]; ns[d] = m_src[d];
      np[d] = m_ptr[d];   nc[d] = m_cnt[d];
      if (rst) begin
        nv[d] = 0; nd[d] = 0; ns[d] = 0; np[d] = 0; nc[d] = 0;
      end else if (!m_valid[d] || get_ready(d)) begin
        g = pick(d);
        if (g >= 0) begin
          nv[d] = 1; nd[d] = get_slice(d, g); ns[d] = g;
          np[d] = (g + 1) % nreq[d];
          nc[d] = m_cnt[d] + 32'd1;
        end else begin
          nv[d] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = nv[d]; m_data[d] = nd[d]; m_src[d] = ns[d];
      m_ptr[d] = np[d];   m_cnt[d] = nc[d];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (if2.req_wready !== 2'b00 || if3.req_wready !== 3'b000) begin
        errors++;
        $display("FAIL reset_wready cycle %0d: got %b/%b required 0/0", c, if2.req_wready, if3.req_wready);
      end
      tick();
      checks++;
      if (if2.out_valid !== 1'b0 || if2.xfer_count !== 32'd0 || if3.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: out_valid=%b xfer_count=%0d (n3 valid=%b) required 0,0,0",
                 c, if2.out_valid, if2.xfer_count, if3.out_valid);
      end
    end
  endtask

  task automatic test_solo();
    if2.req_wvalid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      if2.req_wdata = {32'(5 + k), 32'hDEAD_0000};
      #1;
      checks++;
      if (if2.req_wready !== 2'b10) begin
        errors++;
        $display("FAIL solo_wready word %0d: got %b required 10", k, if2.req_wready);
      end
      tick();
      checks++;
      if (if2.out_valid !== 1'b1 || if2.out_data !== 32'(5 + k) || if2.out_src !== 1'b1) begin
        errors++;
        $display("FAIL solo_out word %0d: got v=%b d=%0h s=%0d required 1,%0h,1",
                 k, if2.out_valid, if2.out_data, if2.out_src, 5 + k);
      end
    end
    if2.req_wvalid = 2'b00;
    tick();
    checks++;
    if (if2.xfer_count !== 32'd3 || if2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL solo_count: got count=%0d valid=%b required 3,0", if2.xfer_count, if2.out_valid);
    end
  endtask

  task automatic test_contention();
    logic [31:0] exp_seq [6] = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2};
    int ka = 0;
    int kb = 0;
    if2.req_wvalid = 2'b11;
    for (int j = 0; j < 6; j++) begin
      if2.req_wdata = {32'(32'hB0 + kb), 32'(32'hA0 + ka)};
      tick();
      checks++;
      if (if2.out_data !== exp_seq[j] || if2.out_src !== 1'((j % 2)) || if2.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL contention item %0d: got d=%0h s=%0d v=%b required %0h,%0d,1",
                 j, if2.out_data, if2.out_src, if2.out_valid, exp_seq[j], j % 2);
      end
      if (j % 2 == 0) ka++; else kb++;
    end
    if2.req_wvalid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    if2.req_wvalid = 2'b01;
    if2.req_wdata  = {32'h0, 32'h11};
    tick();
    if2.out_ready  = 1'b0;
    if2.req_wvalid = 2'b11;
    if2.req_wdata  = {32'h33, 32'h22};
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (if2.req_wready !== 2'b00) begin
        errors++;
        $display("FAIL bp_wready cycle %0d: got %b required 00", c, if2.req_wready);
      end
      tick();
      checks++;
      if (if2.out_data !== 32'h11 || if2.out_valid !== 1'b1 || if2.out_src !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got d=%0h v=%b s=%0d required 11,1,0",
                 c, if2.out_data, if2.out_valid, if2.out_src);
      end
    end
    if2.out_ready = 1'b1;
    #1;
    checks++;
    if (if2.req_wready !== 2'b10) begin
      errors++;
      $display("FAIL bp_release_grant: got %b required 10", if2.req_wready);
    end
    tick();
    checks++;
    if (if2.out_data !== 32'h33 || if2.out_src !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_out: got d=%0h s=%0d required 33,1", if2.out_data, if2.out_src);
    end
    if2.req_wvalid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    if2.req_wvalid = 2'b01;
    if2.req_wdata  = {32'h0, 32'h44};
    tick();
    if2.out_ready  = 1'b0;
    if2.req_wvalid = 2'b11;
    rst = 1'b1;
    #1;
    checks++;
    if (if2.req_wready !== 2'b00 || if3.req_wready !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_wready: got %b/%b required 00/000", if2.req_wready, if3.req_wready);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (if2.out_valid !== 1'b0 || if2.xfer_count !== 32'd0 || if2.out_data !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_state: got v=%b cnt=%0d d=%0h required 0,0,0",
               if2.out_valid, if2.xfer_count, if2.out_data);
    end
    if2.out_ready = 1'b1;
    if2.req_wdata = {32'h77, 32'h66};
    #1;
    checks++;
    if (if2.req_wready !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_first_grant: got %b required 01", if2.req_wready);
    end
    tick();
    checks++;
    if (if2.out_data !== 32'h66 || if2.out_src !== 1'b0 || if2.xfer_count !== 32'd1) begin
      errors++;
      $display("FAIL rstmid_first_out: got d=%0h s=%0d cnt=%0d required 66,0,1",
               if2.out_data, if2.out_src, if2.xfer_count);
    end
    if2.req_wvalid = 2'b00;
    tick();
  endtask

  task automatic test_nonpow2();
    if3.req_wdata  = {32'hC2, 32'hC1, 32'hC0};
    if3.req_wvalid = 3'b111;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (if3.out_src !== 2'(k % 3) || if3.out_data !== 32'(32'hC0 + k % 3)) begin
        errors++;
        $display("FAIL nonpow2 item %0d: got s=%0d d=%0h required %0d,%0h",
                 k, if3.out_src, if3.out_data, k % 3, 32'hC0 + k % 3);
      end
    end
    if3.req_wvalid = 3'b000;
    tick();
    checks++;
    if (if3.xfer_count !== 32'd7) begin
      errors++;
      $display("FAIL nonpow2_count: got %0d required 7", if3.xfer_count);
    end
  endtask

  task automatic test_wrap();
    force u_dut2.xfer_count_q = 32'hFFFF_FFFF;
    #1;
    release u_dut2.xfer_count_q;
    m_cnt[0] = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (if2.xfer_count !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %0h required ffffffff", if2.xfer_count);
    end
    if2.req_wvalid = 2'b10;
    if2.req_wdata  = {32'h99, 32'h0};
    tick();
    checks++;
    if (if2.xfer_count !== 32'd0 || if2.out_data !== 32'h99) begin
      errors++;
      $display("FAIL wrap_count: got cnt=%0h d=%0h required 0,99", if2.xfer_count, if2.out_data);
    end
    if2.req_wvalid = 2'b00;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if2.req_wvalid = 2'($urandom_range(0, 3));
      if3.req_wvalid = 3'($urandom_range(0, 7));
      if2.req_wdata  = {$urandom, $urandom};
      if3.req_wdata  = {$urandom, $urandom, $urandom};
      if2.out_ready  = ($urandom % 4) != 0;
      if3.out_ready  = ($urandom % 3) != 0;
      #1;
      checks++;
      if (8'(if2.req_wready) !== exp_wready(0) || 8'(if3.req_wready) !== exp_wready(1)) begin
        errors++;
        $display("FAIL rnd_wready cycle %0d: got %b/%b required %b/%b",
                 c, if2.req_wready, if3.req_wready, exp_wready(0), exp_wready(1));
      end
      tick();
      checks++;
      if (if2.out_valid !== m_valid[0] || if2.out_data !== m_data[0] ||
          32'(if2.out_src) !== 32'(m_src[0]) || if2.xfer_count !== m_cnt[0]) begin
        errors++;
        $display("FAIL rnd_out_n2 cycle %0d: got v=%b d=%0h s=%0d c=%0d required %b,%0h,%0d,%0d",
                 c, if2.out_valid, if2.out_data, if2.out_src, if2.xfer_count,
                 m_valid[0], m_data[0], m_src[0], m_cnt[0]);
      end
      checks++;
      if (if3.out_valid !== m_valid[1] || if3.out_data !== m_data[1] ||
          32'(if3.out_src) !== 32'(m_src[1]) || if3.xfer_count !== m_cnt[1]) begin
        errors++;
        $display("FAIL rnd_out_n3 cycle %0d: got v=%b d=%0h s=%0d c=%0d required %b,%0h,%0d,%0d",
                 c, if3.out_valid, if3.out_data, if3.out_src, if3.xfer_count,
                 m_valid[1], m_data[1], m_src[1], m_cnt[1]);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_valid[d] = 0; m_data[d] = 0; m_src[d] = 0; m_cnt[d] = 0;
    end
    if2.req_wvalid = '0; if2.req_wdata = '0; if2.out_ready = 1'b1;
    if3.req_wvalid = '0; if3.req_wdata = '0; if3.out_ready = 1'b1;
    test_reset();
    test_solo();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_nonpow2();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
